// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: truth-table sweeper for one 2-input gate.
// Steps {A,B} through 00,01,10,11. Each vector is held for SETTLE cycles,
// then Y is sampled. The 4-bit table is compared against EXPECTED.
module gate_sweep_ctrl #(
  parameter int unsigned SETTLE   = 2,
  parameter logic [3:0]  EXPECTED = 4'b0111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       A,
  output logic       B,
  input  logic       Y,
  output logic       busy,
  output logic       done,
  output logic [3:0] table_out,
  output logic       pass
);

  // Counter only needs to reach SETTLE-1; keep at least one bit for SETTLE=1.
  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t        r_state, w_state;
  logic [1:0]    r_idx, w_idx;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [3:0]    r_shadow, w_shadow;
  logic [3:0]    r_table, w_table;
  logic          r_pass, w_pass;
  logic          r_busy, w_busy;
  logic          r_done, w_done;

  // State and datapath registers; reset clears everything, including the last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_table  <= '0;
      r_pass   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_idx    <= w_idx;
      r_cnt    <= w_cnt;
      r_shadow <= w_shadow;
      r_table  <= w_table;
      r_pass   <= w_pass;
      r_busy   <= w_busy;
      r_done   <= w_done;
    end
  end

  // Next-state logic: launch on start, sample every SETTLE cycles, publish after the 4th sample.
  always_comb begin
    w_state  = r_state;
    w_idx    = r_idx;
    w_cnt    = r_cnt;
    w_shadow = r_shadow;
    w_table  = r_table;
    w_pass   = r_pass;
    w_busy   = r_busy;
    w_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state  = S_RUN;
          w_idx    = '0;
          w_cnt    = '0;
          w_shadow = '0;
          w_busy   = 1'b1;
        end
      end
      S_RUN: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt           = '0;
          w_shadow[r_idx] = Y;
          // idx wraps 3->0, which also returns A/B to 00 for IDLE.
          w_idx           = r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            w_table = w_shadow;
            w_pass  = (w_shadow == EXPECTED);
            w_done  = 1'b1;
            w_busy  = 1'b0;
            w_state = S_IDLE;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  // A/B come directly from the index flops; idx is always 0 while idle.
  assign A         = r_idx[1];
  assign B         = r_idx[0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign table_out = r_table;
  assign pass      = r_pass;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Self-checking bench for gate_sweep_ctrl: three instances (SETTLE 2, 1, 255)
// checked every cycle against a timeline model, plus directed literal checks.
module tb_gate_sweep_ctrl;

  localparam int unsigned S0 = 2;
  localparam int unsigned S1 = 1;
  localparam int unsigned S2 = 255;
  localparam logic [3:0]  EXP = 4'b0111;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [2:0]      start = '0;
  logic [2:0][3:0] gate;
  logic [2:0]      a, b, y, busy, done, pass;
  logic [2:0][3:0] tbl;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  gate_sweep_ctrl #(.SETTLE(S0), .EXPECTED(EXP)) u_d0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .A(a[0]), .B(b[0]), .Y(y[0]),
    .busy(busy[0]), .done(done[0]), .table_out(tbl[0]), .pass(pass[0]));
  gate_sweep_ctrl #(.SETTLE(S1), .EXPECTED(EXP)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .A(a[1]), .B(b[1]), .Y(y[1]),
    .busy(busy[1]), .done(done[1]), .table_out(tbl[1]), .pass(pass[1]));
  gate_sweep_ctrl #(.SETTLE(S2), .EXPECTED(EXP)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .A(a[2]), .B(b[2]), .Y(y[2]),
    .busy(busy[2]), .done(done[2]), .table_out(tbl[2]), .pass(pass[2]));

  // Gate under test: Y is the truth-table bit addressed by {A,B}.
  assign y[0] = gate[0][{a[0], b[0]}];
  assign y[1] = gate[1][{a[1], b[1]}];
  assign y[2] = gate[2][{a[2], b[2]}];

  function automatic int settle_of(input int i);
    return (i == 0) ? S0 : (i == 1) ? S1 : S2;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a sweep accepted at edge t0 samples vector k at edge t0+(k+1)*S
  // and finishes at edge t0+4*S; vector shown is (elapsed edges)/S.
  int       ecount = 0;
  bit       m_active [3];
  int       m_t0     [3];
  bit [3:0] m_shadow [3];
  bit [3:0] m_table  [3];
  bit       m_pass   [3];
  bit       m_done   [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_active[i] = 1'b0; m_t0[i] = 0; m_shadow[i] = '0;
        m_table[i] = '0; m_pass[i] = 1'b0; m_done[i] = 1'b0;
      end
    end else begin
      ecount++;
      for (int i = 0; i < 3; i++) begin
        bit was;
        int el, s, k;
        was = m_active[i];
        s = settle_of(i);
        m_done[i] = 1'b0;
        if (was) begin
          el = ecount - m_t0[i];
          if (el > 0 && (el % s) == 0) begin
            k = el / s - 1;
            m_shadow[i][k] = gate[i][k];
            if (k == 3) begin
              m_table[i]  = m_shadow[i];
              m_pass[i]   = (m_shadow[i] == EXP);
              m_done[i]   = 1'b1;
              m_active[i] = 1'b0;
            end
          end
        end else if (start[i]) begin
          m_active[i] = 1'b1;
          m_t0[i]     = ecount;
          m_shadow[i] = '0;
        end
      end
    end
  end

  // Cycle-by-cycle compare of every instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        int v;
        v = m_active[i] ? (ecount - m_t0[i]) / settle_of(i) : 0;
        chk($sformatf("u%0d.AB", i), {a[i], b[i]}, v);
        chk($sformatf("u%0d.busy", i), busy[i], m_active[i]);
        chk($sformatf("u%0d.done", i), done[i], m_done[i]);
        chk($sformatf("u%0d.table_out", i), tbl[i], m_table[i]);
        chk($sformatf("u%0d.pass", i), pass[i], m_pass[i]);
      end
    end
  end

  // Pulse start for one cycle; returns at the negedge after the accepting edge.
  task automatic sweep_start(input int i);
    @(negedge clk);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  // Count edges until done is seen, bounded by limit.
  task automatic wait_done(input int i, input int n0, input int limit, output int n);
    n = n0;
    while (!done[i] && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1 (simulation did not finish)");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    gate[0] = 4'b0111;
    gate[1] = 4'b0000;
    gate[2] = 4'b0111;
    repeat (2) @(negedge clk);
    // Reset state
    chk("reset table", tbl[0], 0);
    chk("reset busy", busy[0], 0);
    chk("reset AB", {a[0], b[0]}, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // NAND, SETTLE=2
    sweep_start(0);
    chk("t1 busy after edge0", busy[0], 1);
    wait_done(0, 0, 40, n);
    chk("t1 done edge", n, 8);
    chk("t1 table", tbl[0], 4'b0111);
    chk("t1 pass", pass[0], 1);
    @(negedge clk);
    chk("t1 idle AB", {a[0], b[0]}, 0);
    chk("t1 idle busy", busy[0], 0);

    // Y tied low, SETTLE=1
    sweep_start(1);
    wait_done(1, 0, 20, n);
    chk("t2 done edge", n, 4);
    chk("t2 table", tbl[1], 4'b0000);
    chk("t2 pass", pass[1], 0);

    // AND gate, then NAND; table holds until second completion
    gate[0] = 4'b1000;
    sweep_start(0);
    wait_done(0, 0, 40, n);
    chk("t3 and table", tbl[0], 4'b1000);
    chk("t3 and pass", pass[0], 0);
    @(negedge clk);
    gate[0] = 4'b0111;
    sweep_start(0);
    repeat (7) @(negedge clk);
    chk("t3 held table", tbl[0], 4'b1000);
    chk("t3 held pass", pass[0], 0);
    wait_done(0, 7, 40, n);
    chk("t3 nand done edge", n, 8);
    chk("t3 nand table", tbl[0], 4'b0111);
    chk("t3 nand pass", pass[0], 1);

    // start at edges 0,3,5: one sweep; start in done cycle relaunches
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;  // after edge 0
    @(negedge clk);                   // after edge 1
    @(negedge clk); start[0] = 1'b1;  // after edge 2
    @(negedge clk); start[0] = 1'b0;  // after edge 3
    @(negedge clk); start[0] = 1'b1;  // after edge 4
    @(negedge clk); start[0] = 1'b0;  // after edge 5
    wait_done(0, 5, 40, n);
    chk("t4 done edge", n, 8);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    chk("t4 relaunch busy", busy[0], 1);
    chk("t4 done one cycle", done[0], 0);
    wait_done(0, 0, 40, n);
    chk("t4 second done edge", n, 8);

    // Reset mid-sweep after a passing sweep
    chk("t5 prior pass", pass[0], 1);
    sweep_start(0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5 rst table", tbl[0], 0);
    chk("t5 rst pass", pass[0], 0);
    chk("t5 rst busy", busy[0], 0);
    chk("t5 rst AB", {a[0], b[0]}, 0);
    repeat (4) begin
      @(negedge clk);
      chk("t5 no done", done[0], 0);
    end
    rst_n = 1'b1;
    sweep_start(0);
    wait_done(0, 0, 40, n);
    chk("t5 fresh done edge", n, 8);
    chk("t5 fresh table", tbl[0], 4'b0111);
    chk("t5 fresh pass", pass[0], 1);

    // SETTLE=255
    sweep_start(2);
    repeat (254) @(negedge clk);
    chk("t6 cnt terminal", int'(u_d2.r_cnt), 254);
    chk("t6 AB vec0", {a[2], b[2]}, 0);
    @(negedge clk);
    chk("t6 AB vec1", {a[2], b[2]}, 1);
    chk("t6 cnt wrap", int'(u_d2.r_cnt), 0);
    wait_done(2, 255, 1100, n);
    chk("t6 done edge", n, 1020);
    chk("t6 table", tbl[2], 4'b0111);
    chk("t6 pass", pass[2], 1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
